// File: rtl/final_soc_debug_scan_master_if.sv
// final_soc_debug_scan_master_if: command/response handshake between a bring-up controller and the scan master.
interface final_soc_debug_scan_master_if #(
    parameter int DR_WIDTH = 38
);
    logic                cmd_valid;
    logic                cmd_ready;
    logic [1:0]          cmd_ir;
    logic [DR_WIDTH-1:0] cmd_data;
    logic                rsp_valid;
    logic [DR_WIDTH-1:0] rsp_data;

    modport master (
        output cmd_valid, cmd_ir, cmd_data,
        input  cmd_ready, rsp_valid, rsp_data
    );

    modport slave (
        input  cmd_valid, cmd_ir, cmd_data,
        output cmd_ready, rsp_valid, rsp_data
    );
endinterface

// File: rtl/final_soc_debug_scan_master.sv
// final_soc_debug_scan_master: virtual-JTAG scan initiator driving tck, strobes and tdi, capturing tdo.
module final_soc_debug_scan_master #(
    parameter int DR_WIDTH = 38,
    parameter int TCK_DIV  = 4
) (
    input  logic                         clk,
    input  logic                         reset_n,
    final_soc_debug_scan_master_if.slave bus,
    output logic [1:0]                   ir_in,
    output logic                         tck,
    output logic                         tdi,
    input  logic                         tdo,
    output logic                         vs_uir,
    output logic                         vs_cdr,
    output logic                         vs_sdr,
    output logic                         vs_udr,
    output logic                         jtag_state_rti
);
    localparam int CW = $clog2(2 * TCK_DIV);
    localparam int BW = $clog2(DR_WIDTH);
    localparam logic [CW-1:0] LAST     = CW'(2 * TCK_DIV - 1);
    localparam logic [CW-1:0] HALF     = CW'(TCK_DIV);
    localparam logic [CW-1:0] RISE     = CW'(TCK_DIV - 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(DR_WIDTH - 1);

    typedef enum logic [2:0] {IDLE, UIR, CDR, SDR, UDR, RTI, DONE} state_t;

    state_t              state, state_nx;
    logic [CW-1:0]       cnt;
    logic [BW-1:0]       bits;
    logic [DR_WIDTH-1:0] sr;
    logic                scanning, period_end, shift, accept;

    always_ff @(posedge clk) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nx;
    end

    always_comb begin
        scanning       = state inside {UIR, CDR, SDR, UDR, RTI};
        period_end     = scanning && (cnt == LAST);
        shift          = (state == SDR) && (cnt == RISE);
        accept         = (state == IDLE) && bus.cmd_valid;
        state_nx       = state;
        case (state)
            IDLE:    state_nx = accept ? UIR : IDLE;
            UIR:     state_nx = period_end ? CDR : UIR;
            CDR:     state_nx = period_end ? SDR : CDR;
            SDR:     state_nx = (period_end && bits == LAST_BIT) ? UDR : SDR;
            UDR:     state_nx = period_end ? RTI : UDR;
            RTI:     state_nx = period_end ? DONE : RTI;
            default: state_nx = IDLE;
        endcase
        bus.cmd_ready  = state == IDLE;
        bus.rsp_valid  = state == DONE;
        tck            = scanning && (cnt >= HALF);
        vs_uir         = state == UIR;
        vs_cdr         = state == CDR;
        vs_sdr         = state == SDR;
        vs_udr         = state == UDR;
        jtag_state_rti = state == RTI;
    end

    // tdi is re-launched only at period starts so it is stable across the rising tck edge
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt          <= '0;
            bits         <= '0;
            sr           <= '0;
            ir_in        <= '0;
            tdi          <= 1'b0;
            bus.rsp_data <= '0;
        end else begin
            cnt  <= (scanning && !period_end) ? cnt + 1'b1 : '0;
            bits <= (state == SDR) ? bits + BW'(period_end) : '0;
            if (accept) begin
                ir_in <= bus.cmd_ir;
                sr    <= bus.cmd_data;
            end else if (shift) begin
                sr <= {tdo, sr[DR_WIDTH-1:1]};
            end
            if (period_end) tdi <= (state_nx == SDR) && sr[0];
            if (state == RTI && period_end) bus.rsp_data <= sr;
        end
    end
endmodule

// File: doc/final_soc_debug_scan_master.md
Name: final_soc_debug_scan_master

Overview:
Host-side initiator for the Nios II debug slave's virtual-JTAG interface. It accepts one command at a time, each carrying a 2-bit IR value and a DR_WIDTH-bit data word. It generates TCK and the virtual-state strobes (UIR, CDR, SDR, UDR, RTI), shifts the word out on TDI LSB-first, and returns the word captured from TDO. It sits between a test/bring-up controller on the system clock and the debug slave's tck/ir_in/tdi/vs_* inputs, replacing the vendor virtual-JTAG hub in simulation and standalone harnesses.

Parameters:
DR_WIDTH, 38, scan data register length in bits (>=2)
TCK_DIV, 4, clk cycles per TCK half-period (>=1); one TCK period = 2*TCK_DIV clk cycles

Ports:
clk  input  1  system clock; all logic on rising edge
reset_n  input  1  synchronous, active-low reset, sampled on clk rising edge
cmd_valid  input  1  command request
cmd_ready  output  1  high only in IDLE; command accepted on a clk edge with cmd_valid&&cmd_ready
cmd_ir  input  2  IR value for this scan
cmd_data  input  DR_WIDTH  data to shift in
rsp_valid  output  1  one-cycle pulse; rsp_data valid
rsp_data  output  DR_WIDTH  captured TDO word, held until next rsp_valid
ir_in  output  2  IR presented to slave
tck  output  1  generated test clock
tdi  output  1  serial data to slave
tdo  input  1  serial data from slave
vs_uir  output  1  update-IR state
vs_cdr  output  1  capture-DR state
vs_sdr  output  1  shift-DR state
vs_udr  output  1  update-DR state
jtag_state_rti  output  1  run-test-idle state

Behaviour:
- Reset (reset_n=0 at clk edge): next cycle all outputs 0, cmd_ready=1, FSM=IDLE, counters cleared. Applies mid-scan: the scan is abandoned and no rsp_valid is issued.
- TCK: low for TCK_DIV cycles, then high for TCK_DIV cycles. A period starts at the 1->0 (low) phase. TCK stays 0 in IDLE/DONE.
- State outputs (vs_*, rti, tdi, ir_in) change only at period starts, so they are stable across the rising TCK edge.
- FSM: IDLE -> UIR (1 period) -> CDR (1) -> SDR (DR_WIDTH periods) -> UDR (1) -> RTI (1) -> DONE (1 clk) -> IDLE.
- On accept, ir_in <= cmd_ir and shift register sr <= cmd_data. ir_in holds until the next accept.
- Exactly one strobe is high per period, and only for that state's whole duration. No strobe is high in IDLE or DONE.
- SDR: tdi = sr[0] for the whole period.
- At the clk edge where tck goes 0->1 during SDR, sr <= {tdo, sr[DR_WIDTH-1:1]}. After DR_WIDTH shifts, the first-captured bit is in bit 0.
- tdo is ignored outside SDR.
- DONE: rsp_data <= sr and rsp_valid=1 for exactly one cycle. cmd_ready returns to 1 the following cycle.
- Latency: accept at edge N; vs_uir rises at cycle N+1; rsp_valid is high in cycle N+1+(4+DR_WIDTH)*2*TCK_DIV. With the defaults that is N+337.
- cmd_valid while busy is ignored (cmd_ready=0). No queueing. cmd_* may change freely after accept.
- A period counter of width clog2(2*TCK_DIV) and a bit counter of width clog2(DR_WIDTH) both wrap/reload at state boundaries. The bit counter reaches DR_WIDTH-1 on the last SDR period, then the FSM advances.

Test Plan:
- Defaults, tdo looped to tdi, cmd_ir=2'b10, cmd_data=38'h2A_5A5A_5A5A -> rsp_data=38'h2A_5A5A_5A5A; rsp_valid exactly at accept+337; ir_in=2'b10 throughout.
- tdo tied 1, cmd_data=0 -> rsp_data=38'h3F_FFFF_FFFF; tdi=0 in all 38 SDR periods.
- Strobe check: count tck rising edges with each strobe high -> uir=1, cdr=1, sdr=38, udr=1, rti=1; strobes are mutually exclusive and change only while tck=0.
- cmd_valid held high across two commands -> cmd_ready=0 for 337 cycles. Second command accepted at the cycle after rsp_valid. No command is lost or duplicated.
- reset_n=0 for 1 cycle during SDR bit 20 -> next cycle all outputs 0, cmd_ready=1, no rsp_valid. A new scan then completes correctly.
- TCK_DIV=1, DR_WIDTH=8, tdo driven with 8'b1100_0101 (first bit=1) -> rsp_data=8'hA3; latency=1+12*2=25 cycles.
